// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one step per cycle, on
// operand magnitudes; the sign is applied when the last step completes.
// Divide-by-zero and signed overflow are resolved at accept (latency 1).
// Optional feature macro: ALU_MULDIV_FAST_MUL_EN, which makes MUL* ops
// single-cycle through a combinational 2*XLEN multiplier.
`timescale 1ns/1ps
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;    // negate product / quotient at the end
  logic              rneg_q, rneg_d;  // negate remainder (dividend was negative)
  logic [XLEN-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] wk_q, wk_d;      // {acc/remainder, multiplier/quotient}
  logic [XLEN-1:0]   res_q, res_d;

  logic              a_sgn, b_sgn, a_neg, b_neg, accept;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              sc_hit;
  logic [XLEN-1:0]   sc_res;
  logic [XLEN:0]     mul_sum, div_shl, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, mul_fix;
  logic [XLEN-1:0]   quo, rem, fin_res;

  assign in_ready   = (state_q == S_IDLE) && !kill;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_result = res_q;

  // Operand signedness per funct3; MULHSU treats only rs1 as signed.
  // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    if (in_op[2]) begin
      a_sgn = ~in_op[0];
      b_sgn = ~in_op[0];
    end else begin
      a_sgn = (in_op[1:0] == 2'b01) || (in_op[1:0] == 2'b10);
      b_sgn = (in_op[1:0] == 2'b01);
    end
  end

  assign a_neg = a_sgn & in_a[XLEN-1];
  assign b_neg = b_sgn & in_b[XLEN-1];
  assign a_mag = a_neg ? -in_a : in_a;
  assign b_mag = b_neg ? -in_b : in_b;

  // Divide special cases resolved without iterating.
  always_comb begin
    sc_hit = 1'b0;
    sc_res = '0;
    if (in_op[2] && (in_b == '0)) begin
      sc_hit = 1'b1;
      sc_res = in_op[1] ? in_a : '1;
    end else if (in_op[2] && !in_op[0] && (in_a == MIN_INT) && (in_b == '1)) begin
      sc_hit = 1'b1;
      sc_res = in_op[1] ? '0 : in_a;
    end
  end

  // One radix-2 step of each algorithm plus the final sign fix-up.
  always_comb begin
    mul_sum   = {1'b0, wk_q[2*XLEN-1:XLEN]} + (wk_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, wk_q[XLEN-1:1]};
    div_shl   = {wk_q[2*XLEN-1:XLEN], wk_q[XLEN-1]};
    div_trial = div_shl - {1'b0, opnd_q};
    if (!div_trial[XLEN]) div_next = {div_trial[XLEN-1:0], wk_q[XLEN-2:0], 1'b1};
    else                  div_next = {div_shl[XLEN-1:0], wk_q[XLEN-2:0], 1'b0};
    mul_fix = neg_q ? -mul_next : mul_next;
    quo     = div_next[XLEN-1:0];
    rem     = div_next[2*XLEN-1:XLEN];
    if (op_q[2])                 fin_res = op_q[1] ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
    else if (op_q[1:0] == 2'b00) fin_res = mul_fix[XLEN-1:0];
    else                         fin_res = mul_fix[2*XLEN-1:XLEN];
  end

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{XLEN{a_neg}}, in_a};
  assign ext_b     = {{XLEN{b_neg}}, in_b};
  assign fast_prod = ext_a * ext_b;
`endif

  // Next-state and datapath load/step control; kill overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    opnd_d  = opnd_q;
    wk_d    = wk_q;
    res_d   = res_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_d    = in_op;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            opnd_d  = in_op[2] ? b_mag : a_mag;
            wk_d    = {{XLEN{1'b0}}, (in_op[2] ? a_mag : b_mag)};
            cnt_d   = CW'(XLEN - 1);
            state_d = S_CALC;
            if (sc_hit) begin
              res_d   = sc_res;
              state_d = S_DONE;
            end
`ifdef ALU_MULDIV_FAST_MUL_EN
            if (!in_op[2]) begin
              res_d   = (in_op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
              state_d = S_DONE;
            end
`else
`endif
          end
        end
        S_CALC: begin
          wk_d  = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            cnt_d   = '0;
            res_d   = fin_res;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the datapath registers are few and narrow, so all of them are reset to keep out_result defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      opnd_q  <= '0;
      wk_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      opnd_q  <= opnd_d;
      wk_q    <= wk_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors with a result scoreboard for alu_muldiv.
// Stimulus pushes the expected result when it issues an op; a monitor pops
// and compares on every output handshake. Latency, hold, kill and reset
// behaviour are checked by the stimulus thread itself.
`timescale 1ns/1ps
module tb_alu_muldiv;
  localparam int XLEN = 32;
`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_op = '0;
  logic [XLEN-1:0] in_a = '0;
  logic [XLEN-1:0] in_b = '0;
  logic            kill = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_result;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard monitor: one compare per completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'b0, out_valid}, 32'd0);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check({mon_name, "_result"}, out_result, mon_exp);
      end
    end
  end

  // Issue one op, scramble the inputs right after accept, and measure latency.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string name);
    int lat;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = ~op;
    in_a     = ~a;
    in_b     = b ^ 32'h5A5A_0001;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",   {31'b0, in_ready},  32'd1);
    check("rst_out_valid",  {31'b0, out_valid}, 32'd0);
    check("rst_busy",       {31'b0, busy},      32'd0);
    check("rst_out_result", out_result,         32'd0);
    rst = 1'b0;

    // Multiply.
    run_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7xm3");
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh_min");
    run_op(OP_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulhu_min");
    run_op(OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, MUL_LAT, "mulhsu_min");
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max");

    // Divide.
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT, "div_m7_2");
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT, "rem_m7_2");
    run_op(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, "div_7_m2");
    run_op(OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT, "rem_7_m2");
    run_op(OP_DIVU, 32'd100,       32'd7,         32'd14,        DIV_LAT, "divu_100_7");
    run_op(OP_REMU, 32'd100,       32'd7,         32'd2,         DIV_LAT, "remu_100_7");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, DIV_LAT, "divu_max_1");

    // Shortcut cases.
    run_op(OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_by0");
    run_op(OP_REM,  32'd5,         32'd0,         32'd5,         1, "rem_by0");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");

    // Back-pressure: result held for 10 cycles with out_ready low.
    @(posedge clk);
    #1 out_ready = 1'b0;
    run_op(OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, "hold_divu_by0");
    bad = 0;
    repeat (10) begin
      if (!out_valid || out_result !== 32'hFFFF_FFFF || in_ready) bad++;
      @(negedge clk);
    end
    check("hold_stable_cycles_bad", 32'(bad), 32'd0);
    check("hold_in_ready",   {31'b0, in_ready}, 32'd0);
    check("hold_out_result", out_result,        32'hFFFF_FFFF);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_busy",     {31'b0, busy},      32'd0);
    check("hold_release_out_valid",{31'b0, out_valid}, 32'd0);
    check("hold_release_in_ready", {31'b0, in_ready},  32'd1);

    // Kill while idle blocks acceptance.
    @(negedge clk);
    kill = 1'b1; in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd100; in_b = 32'd7;
    #1 check("kill_idle_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1 kill = 1'b0; in_valid = 1'b0;
    check("kill_idle_busy", {31'b0, busy}, 32'd0);

    // Kill during CALC cycle 5: back to IDLE, no result.
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("kill_calc_busy_before", {31'b0, busy}, 32'd1);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill_calc_busy",      {31'b0, busy},      32'd0);
    check("kill_calc_out_valid", {31'b0, out_valid}, 32'd0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("kill_calc_no_result", 32'(bad), 32'd0);
    run_op(OP_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT, "mul_after_kill");

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy",       {31'b0, busy},      32'd0);
    check("midrst_out_valid",  {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready",   {31'b0, in_ready},  32'd1);
    check("midrst_out_result", out_result,         32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(OP_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT, "remu_after_rst");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
